pwm_deadtime: RTL
=================

// Module: pwm_deadtime
// PURPOSE
//  Downstream of the PWM generator. Turns its single pwm_out into a complementary high-side/low-side
//  pair with a guaranteed dead time, so both switches are never on together. Replaces the
//  combinational pwm / ~pwm pair at the chip outputs. Fully synchronous to the 12.5 kHz system clock.
// PARAMETERS
//  DEAD_CYCLES  2  dead time in clk cycles inserted before either output turns on; legal 1..2**CNT_W-1
//  CNT_W        4  dead-time counter width; elaborate-time error if DEAD_CYCLES >= 2**CNT_W or < 1
// PORTS
//  clk          in   1      system clock
//  reset        in   1      synchronous, active-high reset
//  pwm_in       in   1      PWM from pwm generator (registered, same clock domain, no synchronizer)
//  fault_in     in   1      synchronous fault request, active high (used only with the macro)
//  hs_out       out  1      high-side drive, follows pwm_in = 1 after the dead time
//  ls_out       out  1      low-side drive, follows pwm_in = 0 after the dead time
//  dt_active    out  1      1 while in a dead-time state (both drives low)
//  swallowed    out  1      1-cycle pulse when a pwm_in pulse is shorter than the dead time and is dropped
//  fault_out    out  1      latched fault status
// BEHAVIOUR
//  - All outputs registered; hs_out and ls_out are never 1 in the same cycle, in any state or at reset.
//  - Reset (dominates everything, fault included): state=IDLE, cnt=0, hs_out=0, ls_out=0,
//    dt_active=0, swallowed=0, fault_out=0.
//  - States: IDLE, DT_H, HIGH, DT_L, LOW, FAULT (FAULT reachable only with the macro).
//  - IDLE: both low. Next edge: pwm_in=1 -> DT_H, else -> DT_L; cnt<=0. So after reset a full
//    dead time always elapses before any drive goes high.
//  - DT_H: both low, dt_active=1, cnt increments each cycle.
//      pwm_in=0 -> DT_L, cnt<=0, swallowed=1 for one cycle (count restarts, never resumes).
//      pwm_in=1 and cnt==DEAD_CYCLES-1 -> HIGH (hs_out=1 from that edge).
//  - HIGH: hs_out=1. pwm_in=0 -> DT_L, cnt<=0, hs_out=0 at the same edge.
//  - DT_L / LOW: mirror of DT_H / HIGH with ls_out and pwm_in=0.
//  - Timing: the first edge that samples the new pwm_in level drops the active drive. The opposite drive
//    rises exactly DEAD_CYCLES edges later, giving DEAD_CYCLES full cycles with both low.
//  - Net effect: each output's on-time = pwm_in level time - DEAD_CYCLES cycles.
//    Levels held < DEAD_CYCLES+1 cycles produce no pulse and assert swallowed.
//  - pwm_in constant 0% or 100%: the matching drive stays on indefinitely after the first dead time.
//  - cnt saturates inside its range by construction (cleared on every DT entry); no wrap possible.
// CONFIGURATION
//  Macro PWM_DEADTIME_FAULT_EN:
//   defined   - fault_in=1 sampled in any state -> FAULT at next edge: hs_out=0, ls_out=0,
//               dt_active=0, fault_out=1. FAULT is sticky; only reset leaves it (-> IDLE).
//               Fault has priority over all pwm_in transitions in the same cycle.
//   undefined - fault_in ignored (unused input), FAULT state not built, fault_out tied 0.
// TESTING (DEAD_CYCLES=2 unless noted)
//  1 reset held 3 cycles with pwm_in=1 -> all outputs 0; release -> IDLE, DT_H 2 cycles, hs_out=1 on edge 3
//  2 steady 50% pwm_in, period 10 cycles -> hs_out high 3 cycles, ls_out high 3 cycles, 2-cycle gaps,
//    dt_active=1 in gaps, never hs_out&ls_out
//  3 pwm_in high for 2 cycles inside LOW -> no hs_out pulse, swallowed=1 for 1 cycle, ls_out returns
//    after 2 dead cycles
//  4 pwm_in stuck 1 (100%) for 50 cycles -> hs_out=1 continuously after the dead time, ls_out=0
//  5 macro defined: fault_in=1 while hs_out=1 -> next edge both 0, fault_out=1;
//    fault_in=0 and pwm toggling -> outputs stay 0 until reset
//  6 macro undefined: same stimulus as 5 -> no change to outputs, fault_out=0;
//    repeat test 2 with DEAD_CYCLES=1, CNT_W=1 -> 1-cycle gaps

Source files
------------

// File: rtl/pwm_deadtime.sv
`default_nettype none
// ============================================================================
// Module      : pwm_deadtime
// Description : Splits one PWM stream into a complementary high/low-side pair
//               with DEAD_CYCLES of both-off time before either drive turns on.
//               Optional latched fault shutdown via PWM_DEADTIME_FAULT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module pwm_deadtime #(
    parameter int DEAD_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    input  logic fault_in,
    output logic hs_out,
    output logic ls_out,
    output logic dt_active,
    output logic swallowed,
    output logic fault_out
);

    generate
        if (DEAD_CYCLES < 1 || DEAD_CYCLES >= (1 << CNT_W)) begin : g_bad_param
            $error("pwm_deadtime: DEAD_CYCLES must be in 1..2**CNT_W-1");
        end
    endgenerate

    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_dt_h  = 3'd1;
    localparam logic [2:0] c_high  = 3'd2;
    localparam logic [2:0] c_dt_l  = 3'd3;
    localparam logic [2:0] c_low   = 3'd4;
    localparam logic [2:0] c_fault = 3'd5;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEAD_CYCLES - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hs;
    logic             r_ls;
    logic             r_dt;
    logic             r_swallowed;

`ifdef PWM_DEADTIME_FAULT_EN
    logic r_fault;
`else
    logic w_fault_unused;
    assign w_fault_unused = fault_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_idle;
            r_cnt       <= '0;
            r_hs        <= 1'b0;
            r_ls        <= 1'b0;
            r_dt        <= 1'b0;
            r_swallowed <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
            r_fault     <= 1'b0;
`endif
        end else begin
            r_swallowed <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
            // Fault outranks every pwm_in transition and only reset clears it.
            if (fault_in || r_state == c_fault) begin
                r_state <= c_fault;
                r_hs    <= 1'b0;
                r_ls    <= 1'b0;
                r_dt    <= 1'b0;
                r_fault <= 1'b1;
            end else
`endif
            begin
                case (r_state)
                    c_idle: begin
                        r_cnt   <= '0;
                        r_dt    <= 1'b1;
                        r_state <= pwm_in ? c_dt_h : c_dt_l;
                    end
                    c_dt_h: begin
                        if (!pwm_in) begin
                            // Pulse too short: restart the opposite dead time from zero.
                            r_state     <= c_dt_l;
                            r_cnt       <= '0;
                            r_swallowed <= 1'b1;
                        end else if (r_cnt == c_cnt_last) begin
                            r_state <= c_high;
                            r_hs    <= 1'b1;
                            r_dt    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    c_high: begin
                        if (!pwm_in) begin
                            r_state <= c_dt_l;
                            r_cnt   <= '0;
                            r_hs    <= 1'b0;
                            r_dt    <= 1'b1;
                        end
                    end
                    c_dt_l: begin
                        if (pwm_in) begin
                            r_state     <= c_dt_h;
                            r_cnt       <= '0;
                            r_swallowed <= 1'b1;
                        end else if (r_cnt == c_cnt_last) begin
                            r_state <= c_low;
                            r_ls    <= 1'b1;
                            r_dt    <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    c_low: begin
                        if (pwm_in) begin
                            r_state <= c_dt_h;
                            r_cnt   <= '0;
                            r_ls    <= 1'b0;
                            r_dt    <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_idle;
                        r_cnt   <= '0;
                        r_hs    <= 1'b0;
                        r_ls    <= 1'b0;
                        r_dt    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign hs_out    = r_hs;
    assign ls_out    = r_ls;
    assign dt_active = r_dt;
    assign swallowed = r_swallowed;
`ifdef PWM_DEADTIME_FAULT_EN
    assign fault_out = r_fault;
`else
    assign fault_out = 1'b0;
`endif

endmodule
`default_nettype wire
